// File: rtl/bus_arbiter.sv
// Round-robin N-master to 1-slave arbiter for the valid/ready memory bus.
// The grant is held for a whole transfer; a watchdog completes hung transfers with ERROR_DATA.
module bus_arbiter #(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_MASTERS-1:0]              m_valid,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]   m_address,
    input  logic [N_MASTERS*DATA_WIDTH/8-1:0] m_wstrobe,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]              m_ready,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic                              m_irq,
    output logic                              s_valid,
    output logic [ADDR_WIDTH-1:0]             s_address,
    output logic [DATA_WIDTH/8-1:0]           s_wstrobe,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    input  logic                              s_ready,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    input  logic                              s_irq,
    output logic                              timeout
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int GW = $clog2(N_MASTERS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] g_q, g_d;
    logic [GW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [GW-1:0] pick;
    logic          busy, granted_valid, done_ok, to_fire;

    assign m_irq = s_irq;

    // Reset gates the outputs so a transfer caught mid-flight never completes.
    assign busy          = (state_q == S_BUSY) && !reset;
    assign granted_valid = m_valid[g_q];
    assign s_valid       = busy && granted_valid;
    assign done_ok       = s_valid && s_ready;
    assign to_fire       = s_valid && !s_ready && (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign timeout       = to_fire;

    // Scan last+1, last+2, ... so the previous owner is considered last.
    always_comb begin
        int sum;
        pick = last_q;
        for (int k = N_MASTERS; k >= 1; k--) begin
            sum = int'(last_q) + k;
            if (sum >= N_MASTERS) sum = sum - N_MASTERS;
            if (m_valid[GW'(sum)]) pick = GW'(sum);
        end
    end

    always_comb begin
        s_address = '0;
        s_wstrobe = '0;
        s_wdata   = '0;
        if (s_valid) begin
            s_address = m_address[g_q*ADDR_WIDTH +: ADDR_WIDTH];
            s_wstrobe = m_wstrobe[g_q*SW +: SW];
            s_wdata   = m_wdata[g_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        m_ready = '0;
        if (done_ok || to_fire) m_ready[g_q] = 1'b1;
        if (done_ok)      m_rdata = s_rdata;
        else if (to_fire) m_rdata = ERROR_DATA;
        else              m_rdata = '0;
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|m_valid) begin
                    state_d = S_BUSY;
                    g_d     = pick;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                // Dropped valid aborts silently; completion and timeout both hand over.
                if (!granted_valid || done_ok || to_fire) begin
                    state_d = S_IDLE;
                    last_d  = g_q;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            last_q  <= GW'(N_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: 3 masters, TIMEOUT=4, ERROR_DATA=0xDEADBEEF.
module tb_bus_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      m_valid;
    logic [N*AW-1:0]   m_address;
    logic [N*DW/8-1:0] m_wstrobe;
    logic [N*DW-1:0]   m_wdata;
    logic [N-1:0]      m_ready;
    logic [DW-1:0]     m_rdata;
    logic              m_irq;
    logic              s_valid;
    logic [AW-1:0]     s_address;
    logic [DW/8-1:0]   s_wstrobe;
    logic [DW-1:0]     s_wdata;
    logic              s_ready;
    logic [DW-1:0]     s_rdata;
    logic              s_irq;
    logic              timeout;

    int errors = 0;
    int checks = 0;

    bus_arbiter #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4), .ERROR_DATA(ERR)) dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_address(m_address),
        .m_wstrobe(m_wstrobe), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
        .m_irq(m_irq), .s_valid(s_valid), .s_address(s_address), .s_wstrobe(s_wstrobe),
        .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata), .s_irq(s_irq), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; m_valid = '0; m_address = '0; m_wstrobe = '0; m_wdata = '0;
        s_ready = 1'b0; s_rdata = '0; s_irq = 1'b1;
        tick(); tick();
        #1;
        checks++; if ({m_ready, s_valid, timeout, m_rdata} !== '0) begin errors++;
            $display("FAIL reset_outputs: got ready=%b sval=%b to=%b rdata=%h, want all 0", m_ready, s_valid, timeout, m_rdata); end
        checks++; if (m_irq !== 1'b1) begin errors++; $display("FAIL reset_irq: got %b want 1", m_irq); end
        s_irq = 1'b0; reset = 1'b0;
        m_address[0 +: 32] = 32'h100; m_address[32 +: 32] = 32'h2000; m_address[64 +: 32] = 32'h3000;
    endtask

    task automatic test_single();
        tick();
        m_valid = 3'b001; #1;
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL single_arb_cycle: s_valid=%b want 0", s_valid); end
        tick(); #1;
        checks++; if (s_valid !== 1'b1 || s_address !== 32'h100) begin errors++;
            $display("FAIL single_fwd: s_valid=%b addr=%h want 1/00000100", s_valid, s_address); end
        tick(); #1;
        checks++; if (m_ready !== 3'b000) begin errors++; $display("FAIL single_wait: m_ready=%b want 000", m_ready); end
        tick();
        s_ready = 1'b1; s_rdata = 32'hCAFEF00D; #1;
        checks++; if (m_ready !== 3'b001 || m_rdata !== 32'hCAFEF00D) begin errors++;
            $display("FAIL single_done: m_ready=%b rdata=%h want 001/cafef00d", m_ready, m_rdata); end
        tick();
        m_valid = '0; s_ready = 1'b0; #1;
        checks++; if (m_ready !== 3'b000 || m_rdata !== 32'h0) begin errors++;
            $display("FAIL single_idle: m_ready=%b rdata=%h want 000/0", m_ready, m_rdata); end
    endtask

    task automatic test_contention();
        logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        reset = 1'b1; tick(); reset = 1'b0;
        m_valid = 3'b111; s_ready = 1'b1; s_rdata = 32'h5A5A0000;
        for (int t = 0; t < 6; t++) begin
            #1;
            checks++; if (m_ready !== 3'b000) begin errors++; $display("FAIL contend_arb%0d: m_ready=%b want 000", t, m_ready); end
            tick(); #1;
            checks++; if (m_ready !== exp_g[t]) begin errors++; $display("FAIL contend_grant%0d: m_ready=%b want %b", t, m_ready, exp_g[t]); end
            tick();
        end
        m_valid = '0; s_ready = 1'b0;
    endtask

    task automatic test_write();
        tick();
        m_valid = 3'b010; m_wstrobe[4 +: 4] = 4'b0110; m_wdata[32 +: 32] = 32'h11223344; s_rdata = 32'h55;
        tick(); #1;
        checks++; if (s_valid !== 1'b1 || s_address !== 32'h2000 || s_wstrobe !== 4'b0110 || s_wdata !== 32'h11223344) begin errors++;
            $display("FAIL write_fwd: v=%b a=%h st=%b d=%h want 1/2000/0110/11223344", s_valid, s_address, s_wstrobe, s_wdata); end
        checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL write_rdata_idle: rdata=%h want 0", m_rdata); end
        tick();
        s_ready = 1'b1; s_rdata = 32'hAAAA5555; #1;
        checks++; if (m_ready !== 3'b010 || m_rdata !== 32'hAAAA5555) begin errors++;
            $display("FAIL write_done: m_ready=%b rdata=%h want 010/aaaa5555", m_ready, m_rdata); end
        tick();
        m_valid = '0; s_ready = 1'b0; m_wstrobe = '0; m_wdata = '0;
    endtask

    task automatic test_timeout(input logic rdy_last);
        tick();
        m_valid = 3'b001; s_rdata = 32'h12345678;
        for (int c = 1; c <= 3; c++) begin
            tick(); #1;
            checks++; if (m_ready !== 3'b000 || timeout !== 1'b0) begin errors++;
                $display("FAIL timeout_wait%0d: m_ready=%b to=%b want 000/0", c, m_ready, timeout); end
        end
        tick();
        s_ready = rdy_last; #1;
        if (rdy_last) begin
            checks++; if (m_ready !== 3'b001 || timeout !== 1'b0 || m_rdata !== 32'h12345678) begin errors++;
                $display("FAIL timeout_race: ready=%b to=%b rdata=%h want 001/0/12345678", m_ready, timeout, m_rdata); end
        end else begin
            checks++; if (m_ready !== 3'b001 || timeout !== 1'b1 || m_rdata !== ERR) begin errors++;
                $display("FAIL timeout_fire: ready=%b to=%b rdata=%h want 001/1/deadbeef", m_ready, timeout, m_rdata); end
        end
        tick();
        m_valid = '0; s_ready = 1'b0; #1;
        checks++; if (timeout !== 1'b0 || m_ready !== 3'b000) begin errors++;
            $display("FAIL timeout_after: to=%b ready=%b want 0/000", timeout, m_ready); end
    endtask

    task automatic test_reset_busy();
        tick();
        m_valid = 3'b010;
        tick(); tick();
        reset = 1'b1; s_ready = 1'b1; s_rdata = 32'h77; #1;
        checks++; if (m_ready !== 3'b000 || s_valid !== 1'b0) begin errors++;
            $display("FAIL rst_busy_gate: ready=%b sval=%b want 000/0", m_ready, s_valid); end
        tick();
        reset = 1'b0; m_valid = 3'b011; #1;
        checks++; if ({m_ready, s_valid, timeout, m_rdata} !== '0) begin errors++;
            $display("FAIL rst_busy_idle: ready=%b sval=%b to=%b rdata=%h want 0", m_ready, s_valid, timeout, m_rdata); end
        tick(); #1;
        checks++; if (m_ready !== 3'b001 || s_address !== 32'h100) begin errors++;
            $display("FAIL rst_busy_m0wins: ready=%b addr=%h want 001/00000100", m_ready, s_address); end
        tick();
        m_valid = '0; s_ready = 1'b0;
    endtask

    task automatic test_abort_irq();
        // last grant was master 0, so master 1 is scanned first
        tick();
        m_valid = 3'b111;
        tick(); #1;
        checks++; if (s_address !== 32'h2000) begin errors++; $display("FAIL abort_grant1: addr=%h want 00002000", s_address); end
        s_irq = 1'b1; #1;
        checks++; if (m_irq !== 1'b1) begin errors++; $display("FAIL irq_busy_hi: m_irq=%b want 1", m_irq); end
        tick();
        m_valid = 3'b101; #1;
        checks++; if (s_valid !== 1'b0 || s_address !== 32'h0 || m_ready !== 3'b000) begin errors++;
            $display("FAIL abort_drop: sval=%b addr=%h ready=%b want 0/0/000", s_valid, s_address, m_ready); end
        tick();
        m_valid = 3'b111; s_irq = 1'b0; #1;
        checks++; if (m_ready !== 3'b000 || s_valid !== 1'b0) begin errors++;
            $display("FAIL abort_idle: ready=%b sval=%b want 000/0", m_ready, s_valid); end
        checks++; if (m_irq !== 1'b0) begin errors++; $display("FAIL irq_idle_lo: m_irq=%b want 0", m_irq); end
        tick();
        s_ready = 1'b1; #1;
        checks++; if (m_ready !== 3'b100 || s_address !== 32'h3000) begin errors++;
            $display("FAIL abort_skip: ready=%b addr=%h want 100/00003000", m_ready, s_address); end
        tick();
        m_valid = '0; s_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_write();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_busy();
        test_abort_irq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
